uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 99 +++++++++
 tb/tb_uart_rx_fifo.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for a UART receiver.
// The head word falls through to r_data, and the level and flags are registered.
// A write to a full FIFO with no pop is dropped and sets the sticky overflow flag.
module uart_rx_fifo #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned AF_LEVEL   = 12
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic [DBIT-1:0]       w_data,
    input  logic                  rd,
    output logic [DBIT-1:0]       r_data,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    input  logic                  clr_overflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned LW    = ADDR_WIDTH + 1;

    logic [DBIT-1:0]       mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic                  wr_acc;
    logic                  rd_acc;
    logic                  drop;
    logic [LW-1:0]         level_nxt;

    // Accept/drop decisions and next occupancy
    always_comb begin
        wr_acc    = 1'b0;
        rd_acc    = 1'b0;
        drop      = 1'b0;
        level_nxt = level;
        // a full FIFO can still take a write when the same cycle pops the head
        wr_acc = wr && (!full || rd);
        // popping an empty FIFO is silently ignored
        rd_acc = rd && !empty;
        drop   = wr && full && !rd;
        if (wr_acc && !rd_acc) begin
            level_nxt = level + LW'(1);
        end else if (!wr_acc && rd_acc) begin
            level_nxt = level - LW'(1);
        end
    end

    // Pointers, level, flags and sticky overflow
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            level       <= level_nxt;
            // flags are computed from the next level so they move in step with level
            empty       <= (level_nxt == LW'(0));
            full        <= (level_nxt == LW'(DEPTH));
            almost_full <= (level_nxt >= LW'(AF_LEVEL));
            // a new drop wins over a clear in the same cycle
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // Storage array, deliberately not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= w_data;
        end
    end

    // First-word-fall-through head, forced to zero while empty
    always_comb begin
        r_data = '0;
        if (!empty) begin
            r_data = mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo with DEPTH=4, AF_LEVEL=3 and DBIT=8.
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset_n;
    logic       wr;
    logic [7:0] w_data;
    logic       rd;
    logic [7:0] r_data;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [2:0] level;
    logic       overflow;
    logic       clr_overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [7:0] sb[$];

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       c;
        logic       e;
        logic       f;
        logic       af;
        logic [2:0] lvl;
        logic       ov;
        logic [7:0] rdat;
    } vec_t;

    vec_t vecs[$];

    uart_rx_fifo #(
        .DBIT(8),
        .ADDR_WIDTH(2),
        .AF_LEVEL(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr(wr),
        .w_data(w_data),
        .rd(rd),
        .r_data(r_data),
        .empty(empty),
        .full(full),
        .almost_full(almost_full),
        .level(level),
        .overflow(overflow),
        .clr_overflow(clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic chk_outs(input string tag, input logic e, input logic f, input logic af,
                            input logic [2:0] lvl, input logic ov, input logic [7:0] rdat);
        chk({tag, ".empty"}, 32'(empty), 32'(e));
        chk({tag, ".full"}, 32'(full), 32'(f));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        chk({tag, ".level"}, 32'(level), 32'(lvl));
        chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
        chk({tag, ".r_data"}, 32'(r_data), 32'(rdat));
    endtask

    // Drive one cycle; the scoreboard checks the head word of every pop it expects to be accepted
    task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic       rd_ok;
        logic       wr_ok;
        logic [7:0] head;
        wr           = w;
        w_data       = d;
        rd           = r;
        clr_overflow = c;
        rd_ok = r && (sb.size() > 0);
        wr_ok = w && ((sb.size() < 4) || r);
        if (rd_ok) begin
            head = sb.pop_front();
            chk("sb_head", 32'(r_data), 32'(head));
        end
        if (wr_ok) begin
            sb.push_back(d);
        end
        @(posedge clk);
        #1;
        wr           = 1'b0;
        rd           = 1'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic add(input logic w, input logic [7:0] d, input logic r, input logic c,
                       input logic e, input logic f, input logic af, input logic [2:0] lvl,
                       input logic ov, input logic [7:0] rdat);
        vec_t v;
        v.w = w; v.d = d; v.r = r; v.c = c;
        v.e = e; v.f = f; v.af = af; v.lvl = lvl; v.ov = ov; v.rdat = rdat;
        vecs.push_back(v);
    endtask

    initial begin
        // Each entry: wr, w_data, rd, clr | expected empty, full, almost_full, level, overflow, r_data
        // single byte
        add(1, 8'hA5, 0, 0,  0, 0, 0, 3'd1, 0, 8'hA5);
        add(0, 8'h00, 1, 0,  1, 0, 0, 3'd0, 0, 8'h00);
        // fill and wrap
        add(1, 8'h01, 0, 0,  0, 0, 0, 3'd1, 0, 8'h01);
        add(1, 8'h02, 0, 0,  0, 0, 0, 3'd2, 0, 8'h01);
        add(1, 8'h03, 0, 0,  0, 0, 1, 3'd3, 0, 8'h01);
        add(1, 8'h04, 0, 0,  0, 1, 1, 3'd4, 0, 8'h01);
        add(0, 8'h00, 1, 0,  0, 0, 1, 3'd3, 0, 8'h02);
        add(0, 8'h00, 1, 0,  0, 0, 0, 3'd2, 0, 8'h03);
        add(1, 8'h05, 0, 0,  0, 0, 1, 3'd3, 0, 8'h03);
        add(1, 8'h06, 0, 0,  0, 1, 1, 3'd4, 0, 8'h03);
        // overflow: drop, clear, clear together with a drop, clear again
        add(1, 8'hEE, 0, 0,  0, 1, 1, 3'd4, 1, 8'h03);
        add(0, 8'h00, 0, 1,  0, 1, 1, 3'd4, 0, 8'h03);
        add(1, 8'hEF, 0, 1,  0, 1, 1, 3'd4, 1, 8'h03);
        add(0, 8'h00, 0, 1,  0, 1, 1, 3'd4, 0, 8'h03);
        // write and pop together while full
        add(1, 8'h07, 1, 0,  0, 1, 1, 3'd4, 0, 8'h04);
        add(0, 8'h00, 1, 0,  0, 0, 1, 3'd3, 0, 8'h05);
        add(0, 8'h00, 1, 0,  0, 0, 0, 3'd2, 0, 8'h06);
        add(0, 8'h00, 1, 0,  0, 0, 0, 3'd1, 0, 8'h07);
        add(0, 8'h00, 1, 0,  1, 0, 0, 3'd0, 0, 8'h00);
        // write and pop together while empty
        add(1, 8'h33, 1, 0,  0, 0, 0, 3'd1, 0, 8'h33);
        add(0, 8'h00, 1, 0,  1, 0, 0, 3'd0, 0, 8'h00);
        // underflow, then a normal write and read
        add(0, 8'h00, 1, 0,  1, 0, 0, 3'd0, 0, 8'h00);
        add(0, 8'h00, 1, 0,  1, 0, 0, 3'd0, 0, 8'h00);
        add(0, 8'h00, 1, 0,  1, 0, 0, 3'd0, 0, 8'h00);
        add(1, 8'h44, 0, 0,  0, 0, 0, 3'd1, 0, 8'h44);
        add(0, 8'h00, 1, 0,  1, 0, 0, 3'd0, 0, 8'h00);

        reset_n      = 1'b0;
        wr           = 1'b0;
        rd           = 1'b0;
        w_data       = 8'h00;
        clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_outs("reset", 1, 0, 0, 3'd0, 0, 8'h00);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_outs("post_reset", 1, 0, 0, 3'd0, 0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].c);
            chk_outs($sformatf("vec%0d", i), vecs[i].e, vecs[i].f, vecs[i].af,
                     vecs[i].lvl, vecs[i].ov, vecs[i].rdat);
        end

        // reset mid-stream: assert between edges while wr and rd are active
        step(1, 8'h11, 0, 0);
        step(1, 8'h22, 0, 0);
        step(1, 8'h33, 0, 0);
        chk_outs("pre_rst", 0, 0, 1, 3'd3, 0, 8'h11);
        wr     = 1'b1;
        w_data = 8'h99;
        rd     = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        chk_outs("async_rst", 1, 0, 0, 3'd0, 0, 8'h00);
        wr = 1'b0;
        rd = 1'b0;
        sb.delete();
        @(posedge clk);
        #1;
        chk_outs("rst_held", 1, 0, 0, 3'd0, 0, 8'h00);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 8'h5A, 0, 0);
        chk_outs("after_rst_wr", 0, 0, 0, 3'd1, 0, 8'h5A);
        step(0, 8'h00, 1, 0);
        chk_outs("after_rst_rd", 1, 0, 0, 3'd0, 0, 8'h00);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
